csr_regfile: RTL and testbench

Machine-mode CSR storage and trap-state block. It sits beside the Zicsr datapath: it supplies the current CSR value (feeding that stage's CSR input operand) and commits the new CSR value that stage computes. It also owns the free-running cycle and retired-instruction counters, and produces the ecall/mret PC redirect for the fetch stage.

---
 rtl/csr_regfile_if.sv | 25 ++
 rtl/csr_regfile.sv | 135 +++++++++++++
 tb/tb_csr_regfile.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/csr_regfile_if.sv
// Zicsr-stage <-> CSR regfile bus: address/data, retire strobe, trap controls and PC redirect.
interface csr_regfile_if;
  logic [11:0] csr_addr;
  logic        csr_re;
  logic        csr_we;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        illegal_csr;
  logic        instr_retire;
  logic        ecall;
  logic        mret;
  logic [63:0] pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output csr_addr, csr_re, csr_we, csr_wdata, instr_retire, ecall, mret, pc,
    input  csr_rdata, illegal_csr, redirect_valid, redirect_pc
  );

  modport slave (
    input  csr_addr, csr_re, csr_we, csr_wdata, instr_retire, ecall, mret, pc,
    output csr_rdata, illegal_csr, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: mstatus/mtvec/mscratch/mepc/mcause, cycle and instret
// counters, hart id, and the ecall/mret redirect to fetch.
module csr_regfile #(
  parameter logic [63:0] HART_ID     = 64'd0,
  parameter logic [63:0] MTVEC_RESET = 64'h0
) (
  input logic         clk,
  input logic         rst,
  csr_regfile_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  logic        r_mie;
  logic        r_mpie;
  logic [63:0] r_mtvec;
  logic [63:0] r_mscratch;
  logic [63:0] r_mepc;
  logic [63:0] r_mcause;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic        w_impl;
  logic        w_read_only;
  logic        w_illegal;
  logic        w_trap;
  logic        w_wr;
  logic [63:0] w_mstatus;
  logic [63:0] w_rdata;

  always_comb begin
    w_impl = 1'b0;
    case (bus.csr_addr)
      ADDR_MSTATUS, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC, ADDR_MCAUSE,
      ADDR_MCYCLE, ADDR_MINSTRET, ADDR_MHARTID: w_impl = 1'b1;
      default: w_impl = 1'b0;
    endcase
  end

  assign w_read_only = (bus.csr_addr[11:10] == 2'b11) || (bus.csr_addr == ADDR_MHARTID);
  assign w_illegal   = !rst && ((((bus.csr_re || bus.csr_we) && !w_impl)) ||
                                (bus.csr_we && w_read_only));
  assign w_trap      = bus.ecall || bus.mret;
  // A trap replaces the whole instruction, so its CSR write never lands.
  assign w_wr        = bus.csr_we && !w_illegal && !w_trap;

  assign w_mstatus = {51'd0, 2'b11, 3'b000, r_mpie, 3'b000, r_mie, 3'b000};

  always_comb begin
    w_rdata = 64'd0;
    case (bus.csr_addr)
      ADDR_MSTATUS:  w_rdata = w_mstatus;
      ADDR_MTVEC:    w_rdata = r_mtvec;
      ADDR_MSCRATCH: w_rdata = r_mscratch;
      ADDR_MEPC:     w_rdata = r_mepc;
      ADDR_MCAUSE:   w_rdata = r_mcause;
      ADDR_MCYCLE:   w_rdata = r_mcycle;
      ADDR_MINSTRET: w_rdata = r_minstret;
      ADDR_MHARTID:  w_rdata = HART_ID;
      default:       w_rdata = 64'd0;
    endcase
  end

  assign bus.csr_rdata   = w_rdata;
  assign bus.illegal_csr = w_illegal;

  always_comb begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'd0;
    if (!rst && bus.ecall) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = {r_mtvec[63:2], 2'b00};
    end else if (!rst && bus.mret) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = r_mepc;
    end
  end

  // Counters run regardless of traps; an explicit write replaces the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end else begin
      if (w_wr && bus.csr_addr == ADDR_MCYCLE)
        r_mcycle <= bus.csr_wdata;
      else
        r_mcycle <= r_mcycle + 64'd1;

      if (w_wr && bus.csr_addr == ADDR_MINSTRET)
        r_minstret <= bus.csr_wdata;
      else if (bus.instr_retire)
        r_minstret <= r_minstret + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= {MTVEC_RESET[63:2], 2'b00};
      r_mscratch <= 64'd0;
      r_mepc     <= 64'd0;
      r_mcause   <= 64'd0;
    end else if (bus.ecall) begin
      r_mepc   <= {bus.pc[63:2], 2'b00};
      r_mcause <= 64'd11;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (bus.mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wr) begin
      case (bus.csr_addr)
        ADDR_MSTATUS: begin
          r_mie  <= bus.csr_wdata[3];
          r_mpie <= bus.csr_wdata[7];
        end
        ADDR_MTVEC:    r_mtvec    <= {bus.csr_wdata[63:2], 2'b00};
        ADDR_MSCRATCH: r_mscratch <= bus.csr_wdata;
        ADDR_MEPC:     r_mepc     <= {bus.csr_wdata[63:2], 2'b00};
        ADDR_MCAUSE:   r_mcause   <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed test-plan steps followed by randomized traffic, all checked against a
// behavioural CSR model with immediate assertions.
module tb_csr_regfile;

  localparam logic [63:0] HART = 64'd5;
  localparam logic [63:0] TVEC_RST = 64'h8000_0003;

  logic clk;
  logic rst;
  csr_regfile_if bus ();

  csr_regfile #(.HART_ID(HART), .MTVEC_RESET(TVEC_RST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic        mMie, mMpie;
  logic [63:0] mTvec, mScratch, mEpc, mCause, mCycle, mInstret;

  task automatic modelReset();
    mMie = 1'b0; mMpie = 1'b0;
    mTvec = TVEC_RST & ~64'd3;
    mScratch = 64'd0; mEpc = 64'd0; mCause = 64'd0;
    mCycle = 64'd0; mInstret = 64'd0;
  endtask

  function automatic bit isImpl(input logic [11:0] a);
    return a == 12'h300 || a == 12'h305 || a == 12'h340 || a == 12'h341 ||
           a == 12'h342 || a == 12'hB00 || a == 12'hB02 || a == 12'hF14;
  endfunction

  function automatic logic expIllegal(input logic [11:0] a, input logic re, input logic we);
    return ((re || we) && !isImpl(a)) || (we && (a[11:10] == 2'b11 || a == 12'hF14));
  endfunction

  function automatic logic [63:0] modelRead(input logic [11:0] a);
    case (a)
      12'h300: return 64'h1800 + (mMpie ? 64'h80 : 64'h0) + (mMie ? 64'h8 : 64'h0);
      12'h305: return mTvec;
      12'h340: return mScratch;
      12'h341: return mEpc;
      12'h342: return mCause;
      12'hB00: return mCycle;
      12'hB02: return mInstret;
      12'hF14: return HART;
      default: return 64'd0;
    endcase
  endfunction

  task automatic modelEdge();
    logic        wr;
    logic        oldMie;
    wr = bus.csr_we && !expIllegal(bus.csr_addr, bus.csr_re, bus.csr_we) &&
         !bus.ecall && !bus.mret;
    mCycle = (wr && bus.csr_addr == 12'hB00) ? bus.csr_wdata : mCycle + 64'd1;
    if (wr && bus.csr_addr == 12'hB02) mInstret = bus.csr_wdata;
    else if (bus.instr_retire)         mInstret = mInstret + 64'd1;
    oldMie = mMie;
    if (bus.ecall) begin
      mEpc = bus.pc & ~64'd3; mCause = 64'd11; mMpie = oldMie; mMie = 1'b0;
    end else if (bus.mret) begin
      mMie = mMpie; mMpie = 1'b1;
    end else if (wr) begin
      case (bus.csr_addr)
        12'h300: begin mMie = bus.csr_wdata[3]; mMpie = bus.csr_wdata[7]; end
        12'h305: mTvec = bus.csr_wdata & ~64'd3;
        12'h340: mScratch = bus.csr_wdata;
        12'h341: mEpc = bus.csr_wdata & ~64'd3;
        12'h342: mCause = bus.csr_wdata;
        default: ;
      endcase
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] a, input logic re, input logic we,
                               input logic [63:0] wd, input logic ret, input logic ec,
                               input logic mr, input logic [63:0] p);
    bus.csr_addr = a; bus.csr_re = re; bus.csr_we = we; bus.csr_wdata = wd;
    bus.instr_retire = ret; bus.ecall = ec; bus.mret = mr; bus.pc = p;
    #1;
  endtask

  task automatic readOnly(input logic [11:0] a);
    applyStimulus(a, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  // Compare all outputs with the model, then take one clock edge.
  task automatic stepCycle();
    logic [63:0] expPc;
    expPc = bus.ecall ? (mTvec & ~64'd3) : (bus.mret ? mEpc : 64'd0);
    checkOutput("rdata", bus.csr_rdata, modelRead(bus.csr_addr));
    checkOutput("illegal", 64'(bus.illegal_csr), 64'(expIllegal(bus.csr_addr, bus.csr_re, bus.csr_we)));
    checkOutput("redir_valid", 64'(bus.redirect_valid), 64'(bus.ecall || bus.mret));
    checkOutput("redir_pc", bus.redirect_pc, expPc);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    modelReset();
    applyStimulus(12'h300, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'h40);
    checkOutput("rst_redir_valid", 64'(bus.redirect_valid), 64'd0);
    checkOutput("rst_redir_pc", bus.redirect_pc, 64'd0);
    checkOutput("rst_mstatus", bus.csr_rdata, 64'h1800);
    @(negedge clk);
    readOnly(12'h305); checkOutput("rst_mtvec", bus.csr_rdata, 64'h8000_0000);
    readOnly(12'hB00); checkOutput("rst_mcycle", bus.csr_rdata, 64'd0);
    readOnly(12'hF14); checkOutput("rst_mhartid", bus.csr_rdata, HART);
    checkOutput("rst_illegal", 64'(bus.illegal_csr), 64'd0);
    rst = 1'b0;

    readOnly(12'hB00);
    for (int i = 0; i < 10; i++) stepCycle();
    checkOutput("mcycle_10", bus.csr_rdata, 64'd10);

    applyStimulus(12'h305, 1'b1, 1'b1, 64'h8000_0103, 1'b0, 1'b0, 1'b0, 64'd0);
    stepCycle();
    readOnly(12'h305); checkOutput("mtvec_mask", bus.csr_rdata, 64'h8000_0100);
    applyStimulus(12'h300, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 64'd0);
    stepCycle();
    readOnly(12'h300); checkOutput("mstatus_mask", bus.csr_rdata, 64'h1888);

    applyStimulus(12'h340, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 64'h8000_0040);
    checkOutput("ecall_valid", 64'(bus.redirect_valid), 64'd1);
    checkOutput("ecall_pc", bus.redirect_pc, 64'h8000_0100);
    stepCycle();
    readOnly(12'h341); checkOutput("ecall_mepc", bus.csr_rdata, 64'h8000_0040);
    readOnly(12'h342); checkOutput("ecall_mcause", bus.csr_rdata, 64'd11);
    readOnly(12'h300); checkOutput("ecall_mstatus", bus.csr_rdata, 64'h1880);

    applyStimulus(12'h300, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd0);
    checkOutput("mret_pc", bus.redirect_pc, 64'h8000_0040);
    stepCycle();
    readOnly(12'h300); checkOutput("mret_mstatus", bus.csr_rdata, 64'h1888);

    applyStimulus(12'hB00, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 64'd0);
    stepCycle();
    readOnly(12'hB00); checkOutput("mcycle_max", bus.csr_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    stepCycle();
    checkOutput("mcycle_wrap", bus.csr_rdata, 64'd0);
    applyStimulus(12'hB02, 1'b1, 1'b1, 64'd5, 1'b1, 1'b0, 1'b0, 64'd0);
    stepCycle();
    readOnly(12'hB02); checkOutput("minstret_wr_wins", bus.csr_rdata, 64'd5);

    applyStimulus(12'hF14, 1'b1, 1'b1, 64'd99, 1'b0, 1'b0, 1'b0, 64'd0);
    checkOutput("ro_illegal", 64'(bus.illegal_csr), 64'd1);
    stepCycle();
    readOnly(12'hF14); checkOutput("ro_unchanged", bus.csr_rdata, HART);
    applyStimulus(12'h7C0, 1'b0, 1'b1, 64'd7, 1'b0, 1'b0, 1'b0, 64'd0);
    checkOutput("unimpl_illegal", 64'(bus.illegal_csr), 64'd1);
    stepCycle();
    readOnly(12'h7C0); checkOutput("unimpl_rdata", bus.csr_rdata, 64'd0);

    applyStimulus(12'h340, 1'b1, 1'b1, 64'h1234, 1'b0, 1'b0, 1'b0, 64'd0);
    stepCycle();
    applyStimulus(12'h340, 1'b1, 1'b1, 64'hDEAD, 1'b0, 1'b1, 1'b0, 64'h100);
    stepCycle();
    readOnly(12'h340); checkOutput("ecall_drops_wr", bus.csr_rdata, 64'h1234);

    // Asynchronous reset between edges must clear state without waiting for a clock.
    applyStimulus(12'hB00, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'h0);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("midrst_mcycle", bus.csr_rdata, 64'd0);
    checkOutput("midrst_redir", 64'(bus.redirect_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    readOnly(12'hB00);
    stepCycle();
    checkOutput("midrst_restart", bus.csr_rdata, 64'd1);

    for (int n = 0; n < 400; n++) begin
      logic [11:0] a;
      logic        we, ec, mr;
      case ($urandom_range(0, 11))
        0: a = 12'h300;  1: a = 12'h305;  2: a = 12'h340;  3: a = 12'h341;
        4: a = 12'h342;  5: a = 12'hB00;  6: a = 12'hB02;  7: a = 12'hF14;
        8: a = 12'h7C0;  9: a = 12'hC00;  10: a = 12'h301;
        default: a = 12'($urandom);
      endcase
      we = ($urandom_range(0, 9) < 4);
      ec = ($urandom_range(0, 9) == 0);
      mr = ($urandom_range(0, 9) == 0);
      if ((ec || mr) && (a == 12'hB00 || a == 12'hB02)) we = 1'b0;
      applyStimulus(a, 1'($urandom), we, {32'($urandom), 32'($urandom)},
                    1'($urandom), ec, mr, {32'($urandom), 32'($urandom)});
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
